// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- fetch stage of the cotm32 core
//
// Owns the fetch PC, issues word reads to instruction memory and buffers the
// returned words in a small in-order FIFO. The FIFO head is presented to decode
// as {o_inst, o_pc} over a valid/ready handshake. A redirect flushes buffered
// words, discards every response still in flight and restarts at the target.
//
// Parameters
//   XLEN        data/address width
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  instruction buffer entries (power of 2, >= 2); also the bound
//               on in-flight requests plus buffered words
//
// Ports
//   i_clk             clock, all state updates on the rising edge
//   i_rst             synchronous reset, active-high
//   o_imem_req_valid  read request valid (held until accepted)
//   i_imem_req_ready  memory accepts the request this cycle
//   o_imem_req_addr   word-aligned read address (held until accepted)
//   i_imem_rsp_valid  read data valid, in order, >= 1 cycle after acceptance
//   i_imem_rsp_data   read data (instruction word)
//   i_redirect        redirect fetch (taken branch / jal / jalr / trap)
//   i_redirect_pc     redirect target
//   o_valid           o_inst/o_pc hold a valid instruction
//   i_ready           decode consumes the head entry when o_valid && i_ready
//   o_inst            instruction word at the FIFO head
//   o_pc              address of o_inst
//   o_misalign        present only when COTM32_IF_MISALIGN_EN is defined:
//                     head entry is a nop standing in for a misaligned target
//
// Build option
//   COTM32_IF_MISALIGN_EN  when defined, a redirect to a target with nonzero
//   bits[1:0] issues no fetch; it queues a single nop entry carrying the raw
//   target and o_misalign=1, and fetching stalls until the next redirect.
//   When undefined, target bits[1:0] are cleared and fetch proceeds normally.
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [XLEN-1:0] i_imem_rsp_data,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc
`ifdef COTM32_IF_MISALIGN_EN
  ,
  output logic            o_misalign
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;  // pointer width
  localparam int CW = $clog2(FIFO_DEPTH + 1);                      // holds 0..DEPTH
  localparam int SW = CW + 1;                                      // holds a sum of two counts

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;   // address of the next request to launch
  logic            req_valid_reg, req_valid_next;
  logic [XLEN-1:0] req_addr_reg, req_addr_next;
  logic            stale_reg, stale_next;         // pending request predates a redirect
  logic [CW-1:0]   inflight_reg, inflight_next;   // accepted, response not yet seen
  logic [CW-1:0]   drop_reg, drop_next;           // in-flight responses still to discard
  logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;       // pc of the next kept response
  logic [CW-1:0]   count_reg, count_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;

  // ---------------------------------------------------------------------------
  // Per-cycle events
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            hold;
  logic            rsp;
  logic            rsp_drop;
  logic            push_rsp;
  logic            pop;
  logic            load_nop;
  logic            stall_next;
  logic            launch;
  logic [XLEN-1:0] target_aligned;
  logic [XLEN-1:0] pc_base;
  logic [SW-1:0]   credit_used;
  logic [XLEN-1:0] wr_inst;
  logic [XLEN-1:0] wr_pc;

  assign accept = req_valid_reg && i_imem_req_ready;
  assign hold   = req_valid_reg && !i_imem_req_ready;

  // A response with nothing outstanding is a protocol error; ignoring it keeps
  // the in-flight and drop counters from wrapping.
  assign rsp = i_imem_rsp_valid && (inflight_reg != '0);

  // Responses landing in a redirect cycle belong to the old stream.
  assign rsp_drop = rsp && (i_redirect || (drop_reg != '0));
  assign push_rsp = rsp && !rsp_drop;

  // A pop in a redirect cycle is not an accepted instruction.
  assign pop = (count_reg != '0) && i_ready && !i_redirect;

  // Masking (rather than slicing) keeps every target bit in use in both builds.
  assign target_aligned = i_redirect_pc & ~XLEN'(3);
  assign pc_base        = i_redirect ? target_aligned : fetch_pc_reg;

`ifdef COTM32_IF_MISALIGN_EN
  localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);

  logic stall_reg;

  assign load_nop   = i_redirect && (i_redirect_pc[1:0] != 2'b00);
  assign stall_next = i_redirect ? load_nop : stall_reg;
  assign wr_inst    = load_nop ? NOP_INST : i_imem_rsp_data;
  assign wr_pc      = load_nop ? i_redirect_pc : rsp_pc_reg;
`else
  assign load_nop   = 1'b0;
  assign stall_next = 1'b0;
  assign wr_inst    = i_imem_rsp_data;
  assign wr_pc      = rsp_pc_reg;
`endif

  // ---------------------------------------------------------------------------
  // In-flight and drop accounting
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight_next = inflight_reg + CW'(accept) - CW'(rsp);

    drop_next = drop_reg;
    if (i_redirect) begin
      // Everything still outstanding after this edge is stale, including a
      // request accepted this cycle; a response this cycle is already gone.
      drop_next = inflight_next;
    end else begin
      if (rsp && (drop_reg != '0)) begin
        drop_next = drop_next - CW'(1);
      end
      // A request held across a redirect carries the old address, so its
      // response joins the discard count once it is finally accepted.
      if (accept && stale_reg) begin
        drop_next = drop_next + CW'(1);
      end
    end

    stale_next = stale_reg;
    if (i_redirect) begin
      stale_next = hold;
    end else if (accept) begin
      stale_next = 1'b0;
    end

    rsp_pc_next = rsp_pc_reg;
    if (i_redirect) begin
      rsp_pc_next = target_aligned;
    end else if (push_rsp) begin
      rsp_pc_next = rsp_pc_reg + XLEN'(4);
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (i_redirect) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      if (load_nop) begin
        // The stand-in nop is the only entry after a misaligned redirect.
        count_next  = CW'(1);
        wr_ptr_next = PW'(1);
      end
    end else begin
      count_next  = count_reg + CW'(push_rsp) - CW'(pop);
      rd_ptr_next = rd_ptr_reg + PW'(pop);
      wr_ptr_next = wr_ptr_reg + PW'(push_rsp);
    end
  end

  // ---------------------------------------------------------------------------
  // Request issue
  // ---------------------------------------------------------------------------
  // Credit: a new request may go out only while in-flight plus buffered words
  // stay below the FIFO depth, so every response always has a slot. The
  // credit is evaluated on next-cycle counts, which makes the registered
  // request valid equal to the credit rule on the cycle it is visible.
  assign credit_used = SW'(inflight_next) + SW'(count_next);
  assign launch      = !hold && (credit_used < SW'(FIFO_DEPTH)) && !stall_next;

  always_comb begin
    req_valid_next = hold || launch;
    req_addr_next  = req_addr_reg;
    fetch_pc_next  = pc_base;
    if (launch) begin
      req_addr_next = pc_base;
      fetch_pc_next = pc_base + XLEN'(4);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc_reg  <= RESET_PC;
      req_valid_reg <= 1'b0;
      req_addr_reg  <= RESET_PC;
      stale_reg     <= 1'b0;
      inflight_reg  <= '0;
      drop_reg      <= '0;
      rsp_pc_reg    <= RESET_PC;
      count_reg     <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
    end else begin
      fetch_pc_reg  <= fetch_pc_next;
      req_valid_reg <= req_valid_next;
      req_addr_reg  <= req_addr_next;
      stale_reg     <= stale_next;
      inflight_reg  <= inflight_next;
      drop_reg      <= drop_next;
      rsp_pc_reg    <= rsp_pc_next;
      count_reg     <= count_next;
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
    end
  end

`ifdef COTM32_IF_MISALIGN_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_reg <= 1'b0;
    end else begin
      stall_reg <= stall_next;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FIFO storage: one register slot per entry. Data needs no reset because
  // the outputs are gated by occupancy.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] entry_inst [FIFO_DEPTH];
  logic [XLEN-1:0] entry_pc   [FIFO_DEPTH];
`ifdef COTM32_IF_MISALIGN_EN
  logic            entry_mis  [FIFO_DEPTH];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic            wr_en;
      logic [XLEN-1:0] inst_q;
      logic [XLEN-1:0] pc_q;

      // The nop always lands in slot 0 because a redirect rewinds the pointers.
      assign wr_en = (push_rsp && (wr_ptr_reg == PW'(gi))) || (load_nop && (gi == 0));

      always_ff @(posedge i_clk) begin
        if (wr_en) begin
          inst_q <= wr_inst;
          pc_q   <= wr_pc;
        end
      end

      assign entry_inst[gi] = inst_q;
      assign entry_pc[gi]   = pc_q;

`ifdef COTM32_IF_MISALIGN_EN
      logic mis_q;

      always_ff @(posedge i_clk) begin
        if (wr_en) begin
          mis_q <= load_nop;
        end
      end

      assign entry_mis[gi] = mis_q;
`endif
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_imem_req_valid = req_valid_reg;
  assign o_imem_req_addr  = req_addr_reg;
  assign o_valid          = (count_reg != '0);
  assign o_inst           = o_valid ? entry_inst[rd_ptr_reg] : '0;
  assign o_pc             = o_valid ? entry_pc[rd_ptr_reg]   : '0;
`ifdef COTM32_IF_MISALIGN_EN
  assign o_misalign       = o_valid && entry_mis[rd_ptr_reg];
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch -- directed self-checking bench for inst_fetch
//
// A small memory model answers each accepted request one cycle later (when
// enabled) with data = addr ^ 32'hDEAD_0000. Every tick checks popped words
// against the expected pc stream and accepted request addresses against the
// expected request stream; directed steps check the cycle-exact behaviour.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        o_valid;
  logic        rdy;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
`ifdef COTM32_IF_MISALIGN_EN
  logic        o_misalign;
`endif

  always #5 clk = ~clk;

  inst_fetch dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_imem_req_valid (req_valid),
    .i_imem_req_ready (req_ready),
    .o_imem_req_addr  (req_addr),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .i_redirect       (redirect),
    .i_redirect_pc    (redirect_pc),
    .o_valid          (o_valid),
    .i_ready          (rdy),
    .o_inst           (o_inst),
    .o_pc             (o_pc)
`ifdef COTM32_IF_MISALIGN_EN
    ,
    .o_misalign       (o_misalign)
`endif
  );

  int          checks   = 0;
  int          failures = 0;
  int          pops;
  int          accepts;
  bit          rsp_en;
  bit          req_mon;
  logic [31:0] exp_pc;
  logic [31:0] exp_req_addr;
  logic [31:0] pending [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock: observe the handshakes that will happen at the coming edge,
  // advance to the next negedge, then drive the memory response.
  task automatic tick();
    logic        acc;
    logic [31:0] acc_addr;
    acc      = req_valid && req_ready;
    acc_addr = req_addr;
    if (o_valid && rdy && !redirect) begin
      check("pop_pc", o_pc, exp_pc);
      check("pop_inst", o_inst, exp_pc ^ 32'hDEAD_0000);
`ifdef COTM32_IF_MISALIGN_EN
      check("pop_misalign", 32'(o_misalign), 32'd0);
`endif
      $display("pop  pc=%h inst=%h", o_pc, o_inst);
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (acc) begin
      if (req_mon) check("req_addr", acc_addr, exp_req_addr);
      $display("req  addr=%h", acc_addr);
      exp_req_addr = exp_req_addr + 32'd4;
      accepts++;
    end
    @(posedge clk);
    @(negedge clk);
    if (acc) pending.push_back(acc_addr);
    if (rsp_en && pending.size() > 0) begin
      rsp_valid = 1'b1;
      rsp_data  = pending.pop_front() ^ 32'hDEAD_0000;
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = 32'h0;
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!o_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, 32'(o_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    req_ready   = 1'b1;
    rdy         = 1'b0;
    rsp_en      = 1'b1;
    req_mon     = 1'b1;
    rsp_valid   = 1'b0;
    rsp_data    = 32'h0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    pending.delete();
    rst          = 1'b0;
    exp_pc       = 32'h0;
    exp_req_addr = 32'h0;
    pops         = 0;
    accepts      = 0;
  endtask

  task automatic do_redirect(input logic [31:0] tgt, input logic [31:0] first_pc);
    redirect    = 1'b1;
    redirect_pc = tgt;
    tick();
    redirect    = 1'b0;
    exp_pc      = first_pc;
    pops        = 0;
  endtask

  initial begin
    // ---- reset state ----
    do_reset();
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_req_addr", req_addr, 32'h0);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_inst", o_inst, 32'h0);
    check("rst_o_pc", o_pc, 32'h0);

    // ---- streaming, memory always ready, 1-cycle responses ----
    rdy = 1'b1;
    tick();
    check("t1_first_req_valid", 32'(req_valid), 32'd1);
    check("t1_first_req_addr", req_addr, 32'h0);
    check("t1_valid_c1", 32'(o_valid), 32'd0);
    tick();
    check("t1_valid_c2", 32'(o_valid), 32'd0);
    check("t1_req_addr_c2", req_addr, 32'h4);
    tick();
    check("t1_valid_c3", 32'(o_valid), 32'd1);
    check("t1_pc_c3", o_pc, 32'h0);
    check("t1_inst_c3", o_inst, 32'hDEAD_0000);
    ticks(12);
    check("t1_progress", 32'(pops >= 4), 32'd1);

    // ---- decode stalled: credit stops issue at FIFO_DEPTH ----
    do_reset();
    check("t2_rst_o_valid", 32'(o_valid), 32'd0);
    ticks(10);
    check("t2_accepts", 32'(accepts), 32'd2);
    check("t2_req_valid", 32'(req_valid), 32'd0);
    check("t2_head_pc", o_pc, 32'h0);
    check("t2_head_inst", o_inst, 32'hDEAD_0000);
    rdy = 1'b1;
    ticks(10);
    check("t2_progress", 32'(pops >= 4), 32'd1);

    // ---- memory stalled: request held stable ----
    do_reset();
    rdy = 1'b1;
    ticks(4);
    check("t3_req_valid", 32'(req_valid), 32'd1);
    check("t3_req_addr", req_addr, 32'h8);
    req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_hold_valid", 32'(req_valid), 32'd1);
      check("t3_hold_addr", req_addr, 32'h8);
    end
    req_ready = 1'b1;
    ticks(10);
    check("t3_progress", 32'(pops >= 4), 32'd1);

    // ---- redirect with two responses outstanding ----
    do_reset();
    rdy    = 1'b1;
    rsp_en = 1'b0;
    ticks(3);
    check("t4_credit_full", 32'(req_valid), 32'd0);
    rsp_en       = 1'b1;
    exp_req_addr = 32'h100;
    do_redirect(32'h100, 32'h100);
    check("t4_flush_valid", 32'(o_valid), 32'd0);
    wait_valid("t4_timeout", 10);
    check("t4_pc", o_pc, 32'h100);
    check("t4_inst", o_inst, 32'hDEAD_0100);
    ticks(6);

    // ---- redirect in the same cycle as a response and a pop ----
    do_reset();
    rdy = 1'b1;
    ticks(3);
    check("t5_pre_valid", 32'(o_valid), 32'd1);
    check("t5_pre_pc", o_pc, 32'h0);
    exp_req_addr = 32'h200;
    do_redirect(32'h200, 32'h200);
    check("t5_flush_valid", 32'(o_valid), 32'd0);
    check("t5_req_valid", 32'(req_valid), 32'd1);
    check("t5_req_addr", req_addr, 32'h200);
    wait_valid("t5_timeout", 10);
    check("t5_pc", o_pc, 32'h200);
    check("t5_inst", o_inst, 32'hDEAD_0200);
    ticks(6);

    // ---- redirect while a request waits for the memory ----
    do_reset();
    rdy = 1'b1;
    ticks(4);
    req_ready = 1'b0;
    do_redirect(32'h400, 32'h400);
    check("t6_old_req_valid", 32'(req_valid), 32'd1);
    check("t6_old_req_addr", req_addr, 32'h8);
    check("t6_flush_valid", 32'(o_valid), 32'd0);
    req_ready = 1'b1;
    tick();
    exp_req_addr = 32'h400;
    check("t6_new_req_addr", req_addr, 32'h400);
    wait_valid("t6_timeout", 10);
    check("t6_pc", o_pc, 32'h400);
    check("t6_inst", o_inst, 32'hDEAD_0400);
    ticks(6);

    // ---- back-to-back redirects, last wins; pc wraps past 2^32 ----
    req_mon = 1'b0;
    do_redirect(32'h500, 32'h500);
    do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8);
    wait_valid("t7_timeout", 10);
    check("t7_pc", o_pc, 32'hFFFF_FFF8);
    ticks(15);
    check("t7_wrap_progress", 32'(pops >= 4), 32'd1);

`ifdef COTM32_IF_MISALIGN_EN
    // ---- misaligned target: nop entry, fetch stalls until next redirect ----
    do_reset();
    ticks(3);
    do_redirect(32'h102, 32'h102);
    check("t8_mis_valid", 32'(o_valid), 32'd1);
    check("t8_mis_pc", o_pc, 32'h102);
    check("t8_mis_inst", o_inst, 32'h0000_0013);
    check("t8_mis_flag", 32'(o_misalign), 32'd1);
    accepts = 0;
    ticks(6);
    check("t8_no_accepts", 32'(accepts), 32'd0);
    check("t8_no_req", 32'(req_valid), 32'd0);
    check("t8_entry_held", 32'(o_valid), 32'd1);
    exp_req_addr = 32'h200;
    do_redirect(32'h200, 32'h200);
    rdy = 1'b1;
    wait_valid("t8_timeout", 10);
    check("t8_pc", o_pc, 32'h200);
    check("t8_inst", o_inst, 32'hDEAD_0200);
    check("t8_flag_clear", 32'(o_misalign), 32'd0);
    ticks(6);
`else
    // ---- unaligned target bits are cleared ----
    do_redirect(32'h30A, 32'h308);
    wait_valid("t8_timeout", 10);
    check("t8_pc", o_pc, 32'h308);
    check("t8_inst", o_inst, 32'hDEAD_0308);
    ticks(6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
